// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: next-PC select encoding and default parameters.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pc_seq_pkg;

  localparam int unsigned DEFAULT_WIDTH     = 32;
  localparam int unsigned DEFAULT_RESET_PC  = 0;
  localparam int unsigned DEFAULT_RAS_DEPTH = 4;

  // Next-PC source, listed from lowest to highest priority.
  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } next_pc_sel_e;

endpackage

// File: rtl/return_addr_stack.sv
// Return-address stack, used only to cross-check jr targets against recorded jal returns.
// Latency: push/pop take effect on the next clk edge; top_dat is combinational from state.
// Backpressure: none; a push when full overwrites the oldest entry and sets sticky overflow.
//
// Ports:
//   clk, rst_n      - clock, async active-low reset (clears count/overflow, not entries)
//   push, push_dat  - write push_dat as the new top entry
//   pop             - discard the top entry (ignored when count is 0)
//   top_dat         - current top entry (undefined while count is 0)
//   count           - number of valid entries, saturates at RAS_DEPTH
//   overflow        - sticky, set when a push overwrote a valid entry
module return_addr_stack #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4,
  localparam int unsigned CW       = $clog2(RAS_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] top_dat,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);

  // wr_ptr points at the slot the next push writes; the top entry sits one below it.
  // Treating the array as a ring lets a full-stack push simply overwrite the oldest slot.
  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    top_ptr;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full;

  assign full     = (count_q == CW'(RAS_DEPTH));
  assign top_ptr  = (wr_ptr_q == '0) ? PW'(RAS_DEPTH - 1) : (wr_ptr_q - PW'(1));
  assign top_dat  = mem_q[top_ptr];
  assign count    = count_q;
  assign overflow = overflow_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    // Push wins if both are ever asserted; the parent never does that.
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(RAS_DEPTH - 1)) ? '0 : (wr_ptr_q + PW'(1));
      if (full) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end else if (pop && (count_q != '0)) begin
      wr_ptr_d = top_ptr;
      count_d  = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage is deliberately unreset: it is never observed while count is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks next PC (jr > j/jal > taken branch > pc+4) and checks jr against a RAS.
// Latency: next PC visible on pc 1 cycle after the decode inputs; RAS flags pulse the cycle after jr.
// Backpressure: stall high freezes pc and RAS and forces the pulse flags low on the following cycle.
//
// Ports:
//   clk, rst_n                               - clock, async active-low reset
//   stall                                    - hold all state
//   is_branch, branch_taken, branch_offset   - conditional branch and sign-extended word offset
//   is_j, is_jal, jump_index                 - absolute jumps and 26-bit index
//   is_jr, read_data1                        - register jump and its target (rs)
//   pc, pc_plus4                             - registered PC and combinational pc+4
//   ras_count, ras_mismatch, ras_underflow, ras_overflow - return-address checking status
// WIDTH >= 32, RESET_PC word-aligned, RAS_DEPTH in 2..16.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(DEFAULT_RESET_PC),
  parameter int unsigned      RAS_DEPTH = DEFAULT_RAS_DEPTH,
  localparam int unsigned     CW        = $clog2(RAS_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             is_branch,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             is_j,
  input  logic             is_jal,
  input  logic [25:0]      jump_index,
  input  logic             is_jr,
  input  logic [WIDTH-1:0] read_data1,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [CW-1:0]    ras_count,
  output logic             ras_mismatch,
  output logic             ras_underflow,
  output logic             ras_overflow
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             mismatch_q, mismatch_d;
  logic             underflow_q, underflow_d;
  next_pc_sel_e     sel;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] j_target;
  logic             ras_push, ras_pop;
  logic [WIDTH-1:0] ras_top;
  logic [CW-1:0]    ras_cnt;

  assign pc_plus4  = pc_q + WIDTH'(4);
  assign br_target = pc_plus4 + (branch_offset << 2);
  assign j_target  = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};

  always_comb begin
    sel = SEL_SEQ;
    if (is_jr) begin
      sel = SEL_JR;
    end else if (is_j || is_jal) begin
      sel = SEL_J;
    end else if (is_branch && branch_taken) begin
      sel = SEL_BR;
    end
  end

  always_comb begin
    pc_d = pc_plus4;
    case (sel)
      SEL_JR:  pc_d = read_data1;
      SEL_J:   pc_d = j_target;
      SEL_BR:  pc_d = br_target;
      default: pc_d = pc_plus4;
    endcase
    if (stall) begin
      pc_d = pc_q;
    end
  end

  // jr takes precedence over jal, so a jal squashed by jr never pushes; this also
  // guarantees push and pop are mutually exclusive.
  always_comb begin
    ras_push    = !stall && is_jal && !is_jr;
    ras_pop     = !stall && is_jr && (ras_cnt != '0);
    mismatch_d  = ras_pop && (ras_top != read_data1);
    underflow_d = !stall && is_jr && (ras_cnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      mismatch_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      mismatch_q  <= mismatch_d;
      underflow_q <= underflow_d;
    end
  end

  return_addr_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (ras_push),
    .push_dat (pc_plus4),
    .pop      (ras_pop),
    .top_dat  (ras_top),
    .count    (ras_cnt),
    .overflow (ras_overflow)
  );

  assign pc            = pc_q;
  assign ras_count     = ras_cnt;
  assign ras_mismatch  = mismatch_q;
  assign ras_underflow = underflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expectations are queued when a step is driven and popped after the edge.
// Latency: each step checks state 1 cycle after its inputs are applied.
// Backpressure: exercises stall hold and the RAS full/empty boundaries.
module tb_pc_sequencer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        mm;
    logic        uf;
    logic        of;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             stall;
  logic             is_branch;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_offset;
  logic             is_j;
  logic             is_jal;
  logic [25:0]      jump_index;
  logic             is_jr;
  logic [WIDTH-1:0] read_data1;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic [CW-1:0]    ras_count;
  logic             ras_mismatch;
  logic             ras_underflow;
  logic             ras_overflow;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  pc_sequencer #(
    .WIDTH     (WIDTH),
    .RESET_PC  (32'h0),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .is_branch     (is_branch),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .is_j          (is_j),
    .is_jal        (is_jal),
    .jump_index    (jump_index),
    .is_jr         (is_jr),
    .read_data1    (read_data1),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .ras_count     (ras_count),
    .ras_mismatch  (ras_mismatch),
    .ras_underflow (ras_underflow),
    .ras_overflow  (ras_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input exp_t e);
    chk({tag, ".pc"},       pc,                   e.pc);
    chk({tag, ".count"},    32'(ras_count),       e.cnt);
    chk({tag, ".mismatch"}, 32'(ras_mismatch),    32'(e.mm));
    chk({tag, ".underflw"}, 32'(ras_underflow),   32'(e.uf));
    chk({tag, ".overflow"}, 32'(ras_overflow),    32'(e.of));
  endtask

  task automatic drv(input logic br, input logic tk, input logic [31:0] off,
                     input logic j, input logic jal, input logic [25:0] idx,
                     input logic jr, input logic [31:0] rd1);
    is_branch     = br;
    branch_taken  = tk;
    branch_offset = off;
    is_j          = j;
    is_jal        = jal;
    jump_index    = idx;
    is_jr         = jr;
    read_data1    = rd1;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 26'h0, 1'b0, 32'h0);
  endtask

  // Queue the expectation for the current inputs, clock once, then compare.
  task automatic step(input string tag, input logic [31:0] e_pc, input int e_cnt,
                      input logic e_mm, input logic e_uf, input logic e_of);
    exp_t e;
    sb.push_back('{pc: e_pc, cnt: 32'(e_cnt), mm: e_mm, uf: e_uf, of: e_of});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk_state(tag, e);
    end
  endtask

  initial begin
    logic [31:0] ras_model[$];
    logic [31:0] exp_pc;
    logic [31:0] popped;

    rst_n = 1'b0;
    stall = 1'b0;
    idle();
    #2;
    chk_state("reset", '{pc: 32'h0, cnt: 32'd0, mm: 1'b0, uf: 1'b0, of: 1'b0});
    #10;
    rst_n = 1'b1;
    #1;
    chk("post_reset.pc", pc, 32'h0);

    // Sequential fetch.
    step("seq1", 32'h4, 0, 1'b0, 1'b0, 1'b0);
    step("seq2", 32'h8, 0, 1'b0, 1'b0, 1'b0);
    step("seq3", 32'hC, 0, 1'b0, 1'b0, 1'b0);

    // Conditional branches from 0x100.
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 26'h40, 1'b0, 32'h0);
    step("j_0x100", 32'h100, 0, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 26'h0, 1'b0, 32'h0);
    step("br_taken", 32'hFC, 0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 26'h40, 1'b0, 32'h0);
    step("j_0x100b", 32'h100, 0, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 26'h0, 1'b0, 32'h0);
    step("br_ntaken", 32'h104, 0, 1'b0, 1'b0, 1'b0);

    // jal / jr round trip.
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 26'h100000, 1'b0, 32'h0);
    step("j_0x400000", 32'h0040_0000, 0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 26'h0100010, 1'b0, 32'h0);
    step("jal", 32'h0040_0040, 1, 1'b0, 1'b0, 1'b0);
    chk("jal.top", dut.u_ras.top_dat, 32'h0040_0004);
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h0040_0004);
    step("jr_match", 32'h0040_0004, 0, 1'b0, 1'b0, 1'b0);

    // Mismatching return: the RAS does not steer the PC, it only flags.
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 26'h0100010, 1'b0, 32'h0);
    step("jal2", 32'h0040_0040, 1, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h1234);
    step("jr_mism", 32'h1234, 0, 1'b1, 1'b0, 1'b0);
    idle();
    step("mism_clr", 32'h1238, 0, 1'b0, 1'b0, 1'b0);

    // Five pushes into a four-entry stack; model drops the oldest on overflow.
    exp_pc = 32'h1238;
    for (int i = 1; i <= 5; i++) begin
      ras_model.push_back(exp_pc + 32'd4);
      if (ras_model.size() > DEPTH) void'(ras_model.pop_front());
      drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 26'(i * 32'h100), 1'b0, 32'h0);
      exp_pc = 32'(i) * 32'h400;
      step($sformatf("push%0d", i), exp_pc, ras_model.size(), 1'b0, 1'b0, i == 5);
    end

    // Four matching pops, then one on an empty stack.
    for (int i = 1; i <= 4; i++) begin
      popped = ras_model.pop_back();
      drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 26'h0, 1'b1, popped);
      step($sformatf("pop%0d", i), popped, ras_model.size(), 1'b0, 1'b0, 1'b1);
    end
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h5000);
    step("pop_empty", 32'h5000, 0, 1'b0, 1'b1, 1'b1);
    idle();
    step("uf_clr", 32'h5004, 0, 1'b0, 1'b0, 1'b1);

    // jr beats j/jal/branch; the squashed jal must not push.
    drv(1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 26'h333, 1'b1, 32'h2000);
    step("prio", 32'h2000, 0, 1'b0, 1'b1, 1'b1);
    idle();
    step("prio_nxt", 32'h2004, 0, 1'b0, 1'b0, 1'b1);

    // Stall during jal, then during a would-be mismatching jr.
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 26'h1000, 1'b0, 32'h0);
    step("jal_pre", 32'h4000, 1, 1'b0, 1'b0, 1'b1);
    stall = 1'b1;
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 26'h800, 1'b0, 32'h0);
    step("stall1", 32'h4000, 1, 1'b0, 1'b0, 1'b1);
    step("stall2", 32'h4000, 1, 1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h0);
    step("stall_jr", 32'h4000, 1, 1'b0, 1'b0, 1'b1);
    stall = 1'b0;
    idle();
    step("unstall", 32'h4004, 1, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle.
    #3;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", '{pc: 32'h0, cnt: 32'd0, mm: 1'b0, uf: 1'b0, of: 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    step("after_rst", 32'h4, 0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
